// File: rtl/drop_tick_receiver.sv
// Brings the asynchronous slow_clk into origin_clk and turns each of its edges into a tick.
// Counts ticks and holds drop_req (req/ack) once per effective period, tracking drops lost while pending.
module drop_tick_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int TICK_W      = 8,
    parameter int MISS_W      = 4
) (
    input  logic              origin_clk,
    input  logic              rst,
    input  logic              slow_clk,
    input  logic              enable,
    input  logic [TICK_W-1:0] period,
    input  logic              drop_ack,
    output logic              tick,
    output logic              drop_req,
    output logic [MISS_W-1:0] missed_cnt,
    output logic [1:0]        dbg_state_o,
    output logic [TICK_W-1:0] dbg_cnt_o
);

    localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_INIT = PRIME_W'(SYNC_STAGES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        REQ   = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [PRIME_W-1:0]     prime_q;
    logic                   tick_q;
    logic                   edge_w;

    state_t                 state_q, state_d;
    logic [TICK_W-1:0]      cnt_q, cnt_d;
    logic [MISS_W-1:0]      missed_q, missed_d;
    logic [TICK_W-1:0]      p_last;
    logic                   done_w;

    assign edge_w = sync_q[SYNC_STAGES-1] ^ prev_q;

    // The priming window hides the edge seen when slow_clk is already high out of reset.
    always_ff @(posedge origin_clk) begin
        if (rst) begin
            sync_q  <= '0;
            prev_q  <= 1'b0;
            prime_q <= PRIME_INIT;
            tick_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], slow_clk};
            prev_q  <= sync_q[SYNC_STAGES-1];
            if (prime_q != '0) begin
                prime_q <= prime_q - 1'b1;
            end
            tick_q  <= edge_w && (prime_q == '0);
        end
    end

    // A period of 0 behaves as 1; comparing with >= lets a shrunk period finish on the next tick.
    assign p_last = ((period == '0) ? TICK_W'(1) : period) - TICK_W'(1);
    assign done_w = tick_q && (cnt_q >= p_last);

    always_ff @(posedge origin_clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            missed_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            missed_q <= missed_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        missed_d = missed_q;
        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = COUNT;
                    cnt_d   = '0;
                end
                COUNT: begin
                    if (done_w) begin
                        cnt_d   = '0;
                        state_d = REQ;
                    end else if (tick_q) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REQ: begin
                    if (done_w) begin
                        cnt_d = '0;
                        if (!drop_ack && (missed_q != '1)) begin
                            missed_d = missed_q + 1'b1;
                        end
                    end else begin
                        if (tick_q) begin
                            cnt_d = cnt_q + 1'b1;
                        end
                        if (drop_ack) begin
                            state_d = COUNT;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign tick        = tick_q;
    assign drop_req    = (state_q == REQ);
    assign missed_cnt  = missed_q;
    assign dbg_state_o = state_q;
    assign dbg_cnt_o   = cnt_q;

endmodule

// File: tb/tb_drop_tick_receiver.sv
// Bench for drop_tick_receiver: tick arrival cycles go through an expected queue,
// period/ack behaviour is table driven, and the multi-cycle corners are hand sequenced.
module tb_drop_tick_receiver;

    logic        origin_clk;
    logic        rst;
    logic        slow_clk;
    logic        enable;
    logic [7:0]  period;
    logic        drop_ack;
    logic        tick;
    logic        drop_req;
    logic [3:0]  missed_cnt;
    logic [1:0]  dbg_state;
    logic [7:0]  dbg_cnt;

    drop_tick_receiver #(.SYNC_STAGES(2), .TICK_W(8), .MISS_W(4)) dut (
        .origin_clk  (origin_clk),
        .rst         (rst),
        .slow_clk    (slow_clk),
        .enable      (enable),
        .period      (period),
        .drop_ack    (drop_ack),
        .tick        (tick),
        .drop_req    (drop_req),
        .missed_cnt  (missed_cnt),
        .dbg_state_o (dbg_state),
        .dbg_cnt_o   (dbg_cnt)
    );

    // clock / reset
    initial begin
        origin_clk = 1'b0;
        forever #5 origin_clk = ~origin_clk;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: run did not finish, required finish before limit");
        $fatal(1, "timeout");
    end

    int          total = 0;
    int          bad   = 0;
    logic [31:0] cyc   = 0;
    int          tick_seen = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // scoreboard: every tick must land on the cycle pushed by toggle_slow
    initial begin
        forever begin
            @(posedge origin_clk);
            #1;
            cyc = cyc + 1;
            if (tick === 1'b1) begin
                tick_seen++;
                check("tick_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("tick_cycle", cyc, exp_q.pop_front());
                end
            end else if (exp_q.size() != 0 && cyc > exp_q[0]) begin
                total++;
                bad++;
                $display("FAIL tick_missing: no tick at cycle %0d, required one", exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge origin_clk);
            #2;
        end
    endtask

    task automatic toggle_slow();
        @(negedge origin_clk);
        slow_clk = ~slow_clk;
        exp_q.push_back(cyc + 32'd3);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        enable   = 1'b0;
        drop_ack = 1'b0;
        step(2);
        check("rst_drop_req", 32'(drop_req), 32'd0);
        check("rst_missed", 32'(missed_cnt), 32'd0);
        rst = 1'b0;
        step(5);
    endtask

    int   ack_cnt   = 0;
    int   reqs_seen = 0;
    logic prev_req  = 1'b0;
    int   cur_ack   = 0;

    task automatic cycle_once();
        step();
        if (drop_req && !prev_req) begin
            reqs_seen++;
            if (cur_ack > 0) ack_cnt = cur_ack;
        end
        prev_req = drop_req;
        drop_ack = 1'b0;
        if (ack_cnt > 0) begin
            ack_cnt--;
            if (ack_cnt == 0) drop_ack = 1'b1;
        end
    endtask

    typedef struct {
        logic [7:0] period;
        int         edges;
        int         gap;
        int         ack_dly;
        int         exp_reqs;
        int         exp_missed;
        logic       exp_req;
    } vec_t;

    vec_t vecs[5];

    initial begin
        // period, edges, gap, ack delay (0 = never), requests, missed, final drop_req
        vecs[0] = '{8'd4, 8,  6, 2, 2, 0,  1'b0};
        vecs[1] = '{8'd1, 20, 5, 0, 1, 15, 1'b1};
        vecs[2] = '{8'd0, 3,  6, 2, 3, 0,  1'b0};
        vecs[3] = '{8'd3, 7,  5, 0, 1, 1,  1'b1};
        vecs[4] = '{8'd2, 6,  5, 1, 3, 0,  1'b0};

        slow_clk = 1'b1;
        period   = 8'd4;
        drop_ack = 1'b0;

        // reset dominates enable; outputs at reset values
        rst    = 1'b1;
        enable = 1'b1;
        step(3);
        check("reset_tick", 32'(tick), 32'd0);
        check("reset_drop_req", 32'(drop_req), 32'd0);
        check("reset_missed", 32'(missed_cnt), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        check("reset_cnt", 32'(dbg_cnt), 32'd0);

        // priming: slow_clk static high through and after reset
        enable = 1'b0;
        rst    = 1'b0;
        begin
            int t0;
            t0 = tick_seen;
            step(10);
            check("prime_no_tick", 32'(tick_seen - t0), 32'd0);
            toggle_slow();
            wait_drain();
            step(3);
            check("single_tick_idle", 32'(tick_seen - t0), 32'd1);
        end

        // table-driven period / ack vectors
        for (int v = 0; v < 5; v++) begin
            do_reset();
            period    = vecs[v].period;
            cur_ack   = vecs[v].ack_dly;
            ack_cnt   = 0;
            reqs_seen = 0;
            enable    = 1'b1;
            step(2);
            prev_req  = drop_req;
            for (int e = 0; e < vecs[v].edges; e++) begin
                toggle_slow();
                for (int g = 0; g < vecs[v].gap; g++) cycle_once();
            end
            for (int g = 0; g < 10; g++) cycle_once();
            drop_ack = 1'b0;
            check("vec_drain", 32'(exp_q.size()), 32'd0);
            check("vec_reqs", 32'(reqs_seen), 32'(vecs[v].exp_reqs));
            check("vec_missed", 32'(missed_cnt), 32'(vecs[v].exp_missed));
            check("vec_final_req", 32'(drop_req), 32'(vecs[v].exp_req));
        end

        // period shrink below current count completes on the next tick
        do_reset();
        period = 8'd8;
        enable = 1'b1;
        step(2);
        for (int e = 0; e < 3; e++) begin
            toggle_slow();
            step(5);
        end
        check("shrink_cnt_before", 32'(dbg_cnt), 32'd3);
        check("shrink_state_before", 32'(dbg_state), 32'd1);
        period = 8'd2;
        toggle_slow();
        step(3);
        check("shrink_req_early", 32'(drop_req), 32'd0);
        step();
        check("shrink_req", 32'(drop_req), 32'd1);
        step(2);

        // ack coinciding with a period completion keeps the request and the miss count
        do_reset();
        period = 8'd1;
        enable = 1'b1;
        step(2);
        toggle_slow();
        step(4);
        check("sim_first_req", 32'(drop_req), 32'd1);
        toggle_slow();
        step(3);
        drop_ack = 1'b1;
        step();
        drop_ack = 1'b0;
        check("sim_req_held", 32'(drop_req), 32'd1);
        check("sim_missed_same", 32'(missed_cnt), 32'd0);
        check("sim_state_req", 32'(dbg_state), 32'd2);
        drop_ack = 1'b1;
        step();
        drop_ack = 1'b0;
        check("ack_clears_req", 32'(drop_req), 32'd0);
        toggle_slow();
        step(4);
        toggle_slow();
        step(4);
        check("miss_counted", 32'(missed_cnt), 32'd1);
        check("miss_req_held", 32'(drop_req), 32'd1);

        // disable mid-request discards it and clears the count, keeps missed_cnt
        period = 8'd4;
        toggle_slow();
        step(4);
        check("dis_cnt_before", 32'(dbg_cnt), 32'd1);
        enable = 1'b0;
        step();
        check("dis_req", 32'(drop_req), 32'd0);
        check("dis_cnt", 32'(dbg_cnt), 32'd0);
        check("dis_state", 32'(dbg_state), 32'd0);
        check("dis_missed_kept", 32'(missed_cnt), 32'd1);
        enable = 1'b1;
        period = 8'd2;
        step();
        toggle_slow();
        step(4);
        check("reen_first_tick_req", 32'(drop_req), 32'd0);
        check("reen_cnt", 32'(dbg_cnt), 32'd1);
        toggle_slow();
        step(4);
        check("reen_second_tick_req", 32'(drop_req), 32'd1);
        wait_drain();

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
